// File: rtl/rv_mul_pipe_if.sv
// Operand/result bundle for the rv_mul_pipe multiplier.
// The optional valid sideband is present only when RV_MUL_VALID_EN is defined.
interface rv_mul_pipe_if #(
    parameter int unsigned XLEN = 64
);
    logic [XLEN-1:0] mul_op1_i;
    logic [XLEN-1:0] mul_op2_i;
    logic [XLEN-1:0] mul_result_o;
`ifdef RV_MUL_VALID_EN
    logic            mul_valid_i;
    logic            mul_valid_o;
`endif

`ifdef RV_MUL_VALID_EN
    modport master (
        output mul_op1_i,
        output mul_op2_i,
        output mul_valid_i,
        input  mul_result_o,
        input  mul_valid_o
    );

    modport slave (
        input  mul_op1_i,
        input  mul_op2_i,
        input  mul_valid_i,
        output mul_result_o,
        output mul_valid_o
    );
`else
    modport master (
        output mul_op1_i,
        output mul_op2_i,
        input  mul_result_o
    );

    modport slave (
        input  mul_op1_i,
        input  mul_op2_i,
        output mul_result_o
    );
`endif
endinterface

// File: rtl/rv_mul_pipe.sv
// Three-stage pipelined XLEN x XLEN -> low-XLEN multiplier for the RV64 MUL instruction.
//   S1: operand registers
//   S2: radix-4 Booth partial products + carry-save reduction to sum/carry rows
//   S3: final carry-propagate add, driven straight onto mul_result_o
// Optional feature macro RV_MUL_VALID_EN adds a valid bit piped alongside the data stages.
module rv_mul_pipe #(
    parameter int unsigned XLEN = 64
) (
    input  logic         clk,
    input  logic         rst,
    rv_mul_pipe_if.slave mul_bus
);

    // Zero-extending op2 by two bits makes the Booth recoding treat it as unsigned; the low
    // XLEN bits of the product are the same for signed operands, so that is all we need.
    localparam int unsigned NumPp  = XLEN / 2 + 1;
    localparam int unsigned ExtW   = XLEN + 3;
    localparam int unsigned MaxLvl = 16;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [NumPp-1:0][XLEN-1:0] pp_arr_t;
    typedef logic [1:0][XLEN-1:0] row_pair_t;

    // One Booth partial product, already shifted to its weight and truncated to XLEN bits.
    function automatic word_t booth_pp(word_t mcand, logic [2:0] sel, int shamt);
        word_t mag;
        logic  neg;
        mag = '0;
        neg = 1'b0;
        unique case (sel)
            3'b000, 3'b111: begin mag = '0;          neg = 1'b0; end
            3'b001, 3'b010: begin mag = mcand;       neg = 1'b0; end
            3'b011:         begin mag = mcand << 1;  neg = 1'b0; end
            3'b100:         begin mag = mcand << 1;  neg = 1'b1; end
            3'b101, 3'b110: begin mag = mcand;       neg = 1'b1; end
        endcase
        if (neg) begin
            mag = ~mag + word_t'(1);
        end
        return mag << shamt;
    endfunction

    // Layered 3:2 compression until two rows remain. Carries shifted out of the top bit
    // are dropped, which is exactly the modulo-2^XLEN behaviour we want.
    function automatic row_pair_t csa_tree(pp_arr_t pp);
        pp_arr_t cur;
        pp_arr_t nxt;
        int      n;
        int      m;
        cur = pp;
        n   = NumPp;
        for (int lvl = 0; lvl < MaxLvl; lvl++) begin
            if (n > 2) begin
                nxt = '0;
                m   = 0;
                for (int j = 0; j < NumPp / 3; j++) begin
                    if (3 * j + 2 < n) begin
                        nxt[m]     = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
                        nxt[m+1]   = ((cur[3*j] & cur[3*j+1]) |
                                      (cur[3*j] & cur[3*j+2]) |
                                      (cur[3*j+1] & cur[3*j+2])) << 1;
                        m          = m + 2;
                    end
                end
                // Rows that did not fill a full group of three pass through unchanged.
                for (int k = 0; k < NumPp; k++) begin
                    if (k >= 3 * (n / 3) && k < n) begin
                        nxt[m] = cur[k];
                        m      = m + 1;
                    end
                end
                cur = nxt;
                n   = m;
            end
        end
        return {cur[1], cur[0]};
    endfunction

    word_t     op1_q, op1_d;
    word_t     op2_q, op2_d;
    word_t     sum_q, sum_d;
    word_t     carry_q, carry_d;
    word_t     result_q, result_d;
    pp_arr_t   pp;
    row_pair_t rows;
    logic [ExtW-1:0] op2_ext;

`ifdef RV_MUL_VALID_EN
    logic valid1_q, valid1_d;
    logic valid2_q, valid2_d;
    logic valid3_q, valid3_d;
`endif

    // S1 next state: capture the operands.
    always_comb begin
        op1_d = mul_bus.mul_op1_i;
        op2_d = mul_bus.mul_op2_i;
    end

    // S2 next state: Booth-recode op2, generate partial products and reduce them.
    always_comb begin
        op2_ext = {2'b00, op2_q, 1'b0};
        pp      = '0;
        for (int i = 0; i < NumPp; i++) begin
            pp[i] = booth_pp(op1_q, op2_ext[2*i +: 3], 2 * i);
        end
        rows    = csa_tree(pp);
        sum_d   = rows[0];
        carry_d = rows[1];
    end

    // S3 next state: resolve the redundant sum/carry form.
    always_comb begin
        result_d = sum_q + carry_q;
    end

`ifdef RV_MUL_VALID_EN
    // Valid sideband next state, one flop per data stage.
    always_comb begin
        valid1_d = mul_bus.mul_valid_i;
        valid2_d = valid1_q;
        valid3_d = valid2_q;
    end
`endif

    // Pipeline registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q    <= '0;
            op2_q    <= '0;
            sum_q    <= '0;
            carry_q  <= '0;
            result_q <= '0;
        end else begin
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

`ifdef RV_MUL_VALID_EN
    // Valid sideband registers, cleared together with the data stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            valid3_q <= 1'b0;
        end else begin
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            valid3_q <= valid3_d;
        end
    end

    assign mul_bus.mul_valid_o = valid3_q;
`endif

    assign mul_bus.mul_result_o = result_q;

endmodule

// File: tb/tb_rv_mul_pipe.sv
// Randomised self-checking bench for rv_mul_pipe; also checks the valid sideband when
// RV_MUL_VALID_EN is defined.
module tb_rv_mul_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv_mul_pipe_if #(.XLEN(64)) u_if ();

    rv_mul_pipe #(.XLEN(64)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .mul_bus (u_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Reference: the last three accepted products, newest first; a reset wipes them all.
    logic [63:0] hist  [3];
    logic        vhist [3];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the reference, then compare away from the edge.
    task automatic step(input logic [63:0] a, input logic [63:0] b, input logic r,
                        input logic v, input string tag);
        u_if.mul_op1_i = a;
        u_if.mul_op2_i = b;
        rst            = r;
`ifdef RV_MUL_VALID_EN
        u_if.mul_valid_i = v;
`endif
        @(posedge clk);
        if (r) begin
            hist  = '{64'd0, 64'd0, 64'd0};
            vhist = '{1'b0, 1'b0, 1'b0};
        end else begin
            hist[2]  = hist[1];
            hist[1]  = hist[0];
            hist[0]  = a * b;
            vhist[2] = vhist[1];
            vhist[1] = vhist[0];
            vhist[0] = v;
        end
        @(negedge clk);
        check_eq(tag, u_if.mul_result_o, hist[2]);
`ifdef RV_MUL_VALID_EN
        check_eq({tag, "_valid"}, {63'd0, u_if.mul_valid_o}, {63'd0, vhist[2]});
`endif
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    logic [63:0] bnd_a [6];
    logic [63:0] bnd_b [6];
    logic [63:0] bnd_e [6];

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;

        hist  = '{64'd0, 64'd0, 64'd0};
        vhist = '{1'b0, 1'b0, 1'b0};

        // Reset held for four edges with live operands on the inputs.
        for (int i = 0; i < 4; i++) step(64'd5, 64'd7, 1'b1, 1'b1, "reset_hold");
        for (int i = 0; i < 3; i++) step(64'd5, 64'd7, 1'b0, 1'b1, "reset_release");
        check_eq("reset_first_result", u_if.mul_result_o, 64'd35);

        // Lone product followed by zeros: visible for exactly one cycle.
        step(64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, "single_in");
        step(64'd0, 64'd0, 1'b0, 1'b0, "single_gap0");
        step(64'd0, 64'd0, 1'b0, 1'b0, "single_gap1");
        check_eq("single_result", u_if.mul_result_o, 64'hFFFF_FFFF_FFFF_FFF4);
        step(64'd0, 64'd0, 1'b0, 1'b0, "single_after");
        check_eq("single_one_cycle", u_if.mul_result_o, 64'd0);

        // Boundary operands with hand-computed products.
        bnd_a[0] = 64'h8000_0000_0000_0000; bnd_b[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        bnd_e[0] = 64'h8000_0000_0000_0000;
        bnd_a[1] = 64'h7FFF_FFFF_FFFF_FFFF; bnd_b[1] = 64'd2;
        bnd_e[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        bnd_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; bnd_b[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        bnd_e[2] = 64'd1;
        bnd_a[3] = 64'h1234_5678_9ABC_DEF0; bnd_b[3] = 64'd0;
        bnd_e[3] = 64'd0;
        bnd_a[4] = 64'd1;                   bnd_b[4] = 64'h8000_0000_0000_0000;
        bnd_e[4] = 64'h8000_0000_0000_0000;
        bnd_a[5] = 64'h8000_0000_0000_0000; bnd_b[5] = 64'h8000_0000_0000_0000;
        bnd_e[5] = 64'd0;
        for (int i = 0; i < 6; i++) begin
            step(bnd_a[i], bnd_b[i], 1'b0, 1'b1, "bnd_in");
            step(64'd0, 64'd0, 1'b0, 1'b0, "bnd_gap0");
            step(64'd0, 64'd0, 1'b0, 1'b0, "bnd_gap1");
            check_eq($sformatf("bnd%0d", i), u_if.mul_result_o, bnd_e[i]);
        end

        // Back-to-back random stream, alternating valid, with a one-cycle reset mid-way.
        for (int i = 0; i < 1024; i++) begin
            r1 = $urandom();
            r2 = $urandom();
            if (i == 500) begin
                step(sext32(r1), sext32(r2), 1'b1, 1'b0, "stream_rst");
                check_eq("stream_rst_zero", u_if.mul_result_o, 64'd0);
            end else begin
                step(sext32(r1), sext32(r2), 1'b0, ((i % 2) == 0), "stream");
            end
        end

        // A few full-width random operands to exercise the upper Booth groups.
        for (int i = 0; i < 64; i++) begin
            step({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b1, "wide");
        end
        for (int i = 0; i < 3; i++) step(64'd0, 64'd0, 1'b0, 1'b0, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rv_mul_pipe.md
Name: rv_mul_pipe

Overview:
- Pipelined 64-bit integer multiplier for the RV64 execute stage (M-extension MUL).
- Returns the low 64 bits of op1 × op2 with a fixed 3-cycle latency.
- Fully pipelined: accepts a new operand pair every cycle, no stalls, no handshake.

Parameters:
- XLEN, 64, operand and result width; only 64 is required and verified.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mul_op1_i  input  XLEN  multiplicand, two's complement.
- mul_op2_i  input  XLEN  multiplier, two's complement.
- mul_result_o  output  XLEN  low XLEN bits of mul_op1_i × mul_op2_i, registered.

Behaviour:
- Arithmetic: result = bits [63:0] of the full 128-bit product. The low half is identical for signed and unsigned interpretation, so no sign control input exists.
- Overflow beyond 64 bits is silently discarded; no flags.
- Pipeline has 3 register stages:
  - S1, at edge N: registers mul_op1_i and mul_op2_i.
  - S2, at edge N+1: radix-4 Booth encoding of op2 (33 partial products, sign-extended/truncated to 64 bits); CSA/Wallace reduction to at most 2 rows (sum, carry), registered.
  - S3, at edge N+2: 64-bit final carry-propagate add of sum+carry, registered and driven directly on mul_result_o.
- Latency: operands sampled at edge N appear on mul_result_o immediately after edge N+2 and hold until edge N+3.
- Throughput: one result per cycle. Back-to-back operands never interfere; each result depends only on its own sampled operands.
- Reset, while rst=1 at a rising edge:
  - All stage registers clear to 0; mul_result_o = 0.
  - First valid result: operands sampled at the first edge with rst=0 appear after the third such edge.
- Reset mid-stream: in-flight products are discarded. Outputs stay 0 until new operands have propagated 3 stages.
- No combinational path from any input to mul_result_o.
- Operand boundary values must be exact (wrap modulo 2^64): 0, 1, -1, 0x8000_0000_0000_0000, 0x7FFF_FFFF_FFFF_FFFF.
- X on inputs may propagate. Reset values must be clean 0.

Optional Feature:
- Macro: RV_MUL_VALID_EN.
- Defined:
  - Adds mul_valid_i (input, 1) and mul_valid_o (output, 1).
  - mul_valid_i is piped through 3 flops aligned to the data stages; mul_valid_o asserts exactly when mul_result_o holds the product of operands sampled with mul_valid_i=1.
  - Reset clears the valid flops to 0.
  - Data stages are unaffected by valid: they always compute.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset: hold rst=1 for 4 cycles with op1=5, op2=7 -> mul_result_o=0 throughout. After release, 35 appears after the 3rd edge.
- Single product: op1=3, op2=-4 (0xFFFF_FFFF_FFFF_FFFC) for one cycle, then 0 -> result 0xFFFF_FFFF_FFFF_FFF4 exactly 3 edges after sampling, for exactly one cycle.
- Boundaries:
  - 0x8000_0000_0000_0000 × -1 -> 0x8000_0000_0000_0000.
  - 0x7FFF_FFFF_FFFF_FFFF × 2 -> 0xFFFF_FFFF_FFFF_FFFE.
  - -1 × -1 -> 1.
  - any × 0 -> 0.
- Streaming: 1024 back-to-back random 32-bit sign-extended operand pairs -> each cycle mul_result_o equals the low 64 bits of the signed product of the operands sampled 3 edges earlier.
- Mid-stream reset: assert rst for 1 cycle during streaming -> result 0 on the next cycle. Products resume 3 edges after new sampling; no stale pre-reset product ever appears.
- With RV_MUL_VALID_EN: pulse valid on alternating cycles -> mul_valid_o reproduces the pattern delayed by 3 cycles, aligned with the corresponding products.
